// File: rtl/tia_horizontal_sync_decoder.sv
// Horizontal sync/blank/colour-burst decoder for the TIA line timing.
// Two-stage pipeline: on hphi1 the horizontal LFSR state is decoded into
// six stage flags; on hphi2 those flags drive the output latches. Every
// output is a flop, so no input reaches an output combinationally.
// HMOVE strobes are held in hmove_pending until the next start-of-line
// folds them into ext_blank, which selects the late end-of-blank code.
module tia_horizontal_sync_decoder #(
  parameter logic [5:0] SHS_CODE  = 6'b111100,  // set HSYNC
  parameter logic [5:0] RHS_CODE  = 6'b110111,  // reset HSYNC, set colour burst
  parameter logic [5:0] RCB_CODE  = 6'b001111,  // reset colour burst
  parameter logic [5:0] RHB_CODE  = 6'b011100,  // normal end of HBLANK
  parameter logic [5:0] LRHB_CODE = 6'b101111   // late (HMOVE) end of HBLANK
) (
  input  logic       clk,
  input  logic       r,
  input  logic       hphi1,
  input  logic       hphi2,
  input  logic [5:0] lfsr_out,
  input  logic       shb,
  input  logic       rsynd,
  input  logic       hmove,
  output logic       hsync,
  output logic       hblank,
  output logic       cburst,
  output logic       ext_blank,
  output logic       hmove_pending
);

  // Stage flags, written by hphi1 and consumed by hphi2.
  logic f_shs;
  logic f_rhs;
  logic f_rcb;
  logic f_rhb;
  logic f_lrhb;
  logic f_start;

  // Stage 1: decode the LFSR state and line-start strobes on hphi1.
  // NOTE: non-blocking assignments let stage 2 read the flag values from
  // before this edge even when hphi1 and hphi2 are high together.
  always_ff @(posedge clk) begin
    if (r) begin
      f_shs   <= 1'b0;
      f_rhs   <= 1'b0;
      f_rcb   <= 1'b0;
      f_rhb   <= 1'b0;
      f_lrhb  <= 1'b0;
      f_start <= 1'b0;
    end else if (hphi1) begin
      f_shs   <= (lfsr_out == SHS_CODE);
      f_rhs   <= (lfsr_out == RHS_CODE);
      f_rcb   <= (lfsr_out == RCB_CODE);
      f_rhb   <= (lfsr_out == RHB_CODE);
      f_lrhb  <= (lfsr_out == LRHB_CODE);
      f_start <= shb | rsynd;
    end
  end

  // Stage 2: apply staged flags to the output latches on hphi2, and track
  // HMOVE strobes until a line start consumes them.
  // NOTE: several assignments to one latch may fire at one edge; the last
  // one in program order wins, so a line start overrides any code effect.
  always_ff @(posedge clk) begin
    if (r) begin
      hsync         <= 1'b0;
      hblank        <= 1'b1;
      cburst        <= 1'b0;
      ext_blank     <= 1'b0;
      hmove_pending <= 1'b0;
    end else begin
      if (hphi2) begin
        if (f_shs) hsync <= 1'b1;
        if (f_rhs) begin
          hsync  <= 1'b0;
          cburst <= 1'b1;
        end
        if (f_rcb) cburst <= 1'b0;
        if (f_rhb && !ext_blank) hblank <= 1'b0;
        if (f_lrhb && ext_blank) begin
          hblank    <= 1'b0;
          ext_blank <= 1'b0;
        end
        if (f_start) begin
          hblank    <= 1'b1;
          hsync     <= 1'b0;
          cburst    <= 1'b0;
          ext_blank <= hmove_pending | hmove;
        end
      end
      // A strobe coinciding with the line start is folded into ext_blank.
      if (hphi2 && f_start) hmove_pending <= 1'b0;
      else if (hmove)       hmove_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tia_horizontal_sync_decoder.sv
// Self-checking bench for tia_horizontal_sync_decoder. The driver updates a
// behavioural model of the line-timing rules every cycle and queues the
// expected outputs; an independent monitor compares each clock edge.
module tb_tia_horizontal_sync_decoder;

  localparam logic [5:0] SHS  = 6'b111100;
  localparam logic [5:0] RHS  = 6'b110111;
  localparam logic [5:0] RCB  = 6'b001111;
  localparam logic [5:0] RHB  = 6'b011100;
  localparam logic [5:0] LRHB = 6'b101111;
  localparam logic [5:0] IDLE = 6'b000000;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       hphi1 = 1'b0;
  logic       hphi2 = 1'b0;
  logic [5:0] lfsr_out = IDLE;
  logic       shb = 1'b0;
  logic       rsynd = 1'b0;
  logic       hmove = 1'b0;
  logic       hsync, hblank, cburst, ext_blank, hmove_pending;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tia_horizontal_sync_decoder dut (
    .clk(clk), .r(r), .hphi1(hphi1), .hphi2(hphi2), .lfsr_out(lfsr_out),
    .shb(shb), .rsynd(rsynd), .hmove(hmove), .hsync(hsync), .hblank(hblank),
    .cburst(cburst), .ext_blank(ext_blank), .hmove_pending(hmove_pending)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // What the last hphi1 decoded: a list of pending line events.
  typedef struct packed {
    logic start;
    logic late_end;
    logic end_blank;
    logic end_burst;
    logic end_sync;
    logic begin_sync;
  } events_t;

  events_t    m_ev;
  logic       m_hsync, m_hblank, m_cburst, m_ext, m_pend;
  logic [4:0] exp_q[$];

  function automatic events_t decode(input logic [5:0] code, input logic s, input logic rs);
    events_t e;
    e.begin_sync = (code == SHS);
    e.end_sync   = (code == RHS);
    e.end_burst  = (code == RCB);
    e.end_blank  = (code == RHB);
    e.late_end   = (code == LRHB);
    e.start      = s | rs;
    return e;
  endfunction

  task automatic model_step();
    events_t    ev_now;
    logic       ns, nb, nc, ne, np;
    if (r) begin
      m_ev = '0;
      {m_hsync, m_hblank, m_cburst, m_ext, m_pend} = 5'b01000;
      return;
    end
    ev_now = m_ev;
    ns = m_hsync; nb = m_hblank; nc = m_cburst; ne = m_ext; np = m_pend;
    if (hphi2) begin
      // A line start restarts everything regardless of the code events.
      if (ev_now.start) begin
        ns = 1'b0; nc = 1'b0; nb = 1'b1;
        ne = m_pend | hmove;
      end else begin
        ns = ev_now.end_sync ? 1'b0 : (ev_now.begin_sync ? 1'b1 : m_hsync);
        nc = ev_now.end_sync ? 1'b1 : (ev_now.end_burst ? 1'b0 : m_cburst);
        if (!m_ext && ev_now.end_blank) nb = 1'b0;
        if (m_ext && ev_now.late_end) begin
          nb = 1'b0; ne = 1'b0;
        end
      end
    end
    np = (hphi2 && ev_now.start) ? 1'b0 : (m_pend | hmove);
    if (hphi1) m_ev = decode(lfsr_out, shb, rsynd);
    {m_hsync, m_hblank, m_cburst, m_ext, m_pend} = {ns, nb, nc, ne, np};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b want %b (hsync,hblank,cburst,ext_blank,hmove_pending)",
               name, cyc, got, want);
    end
  endtask

  // Monitor: every clock edge is an output event; compare against the queue.
  initial begin
    logic [4:0] want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("scoreboard", {hsync, hblank, cburst, ext_blank, hmove_pending}, want);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rr, input logic h1, input logic h2, input logic [5:0] code,
                      input logic s, input logic rs, input logic hm);
    @(negedge clk);
    r = rr; hphi1 = h1; hphi2 = h2; lfsr_out = code; shb = s; rsynd = rs; hmove = hm;
    model_step();
    exp_q.push_back({m_hsync, m_hblank, m_cburst, m_ext, m_pend});
    cyc++;
  endtask

  // One phase slot: hphi1 with the code, gap, hphi2 (optional hmove), gap.
  task automatic slot(input logic [5:0] code, input logic s, input logic rs, input logic hm2);
    step(1'b0, 1'b1, 1'b0, code, s, rs, 1'b0);
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, IDLE, 1'b0, 1'b0, hm2);
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] outs();
    return {hsync, hblank, cburst, ext_blank, hmove_pending};
  endfunction

  initial begin
    logic [5:0] codes [5];
    codes[0] = SHS; codes[1] = RHS; codes[2] = RCB; codes[3] = RHB; codes[4] = LRHB;

    // Reset held with activity on every other input.
    step(1'b1, 1'b1, 1'b0, SHS, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, RHS, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, LRHB, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0);
    settle();
    check("reset_release", outs(), 5'b01000);

    // Normal line without HMOVE.
    slot(IDLE, 1'b1, 1'b0, 1'b0); settle(); check("line_start", outs(), 5'b01000);
    slot(SHS, 1'b0, 1'b0, 1'b0);  settle(); check("shs",        outs(), 5'b11000);
    slot(RHS, 1'b0, 1'b0, 1'b0);  settle(); check("rhs",        outs(), 5'b01100);
    slot(RCB, 1'b0, 1'b0, 1'b0);  settle(); check("rcb",        outs(), 5'b01000);
    slot(RHB, 1'b0, 1'b0, 1'b0);  settle(); check("rhb",        outs(), 5'b00000);

    // HMOVE extended blank.
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b1);
    settle(); check("hmove_latch", outs(), 5'b00001);
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b1);  // absorbed second strobe
    slot(IDLE, 1'b1, 1'b0, 1'b0); settle(); check("ext_start",  outs(), 5'b01010);
    slot(RHB, 1'b0, 1'b0, 1'b0);  settle(); check("rhb_ignored", outs(), 5'b01010);
    slot(LRHB, 1'b0, 1'b0, 1'b0); settle(); check("lrhb",       outs(), 5'b00000);

    // hmove on the same edge that applies the line start.
    slot(IDLE, 1'b1, 1'b0, 1'b1); settle(); check("hmove_same_edge", outs(), 5'b01010);
    slot(LRHB, 1'b0, 1'b0, 1'b0); settle(); check("lrhb2", outs(), 5'b00000);

    // rsynd mid-line.
    slot(SHS, 1'b0, 1'b0, 1'b0);  settle(); check("mid_sync", outs(), 5'b10000);
    slot(IDLE, 1'b0, 1'b1, 1'b0); settle(); check("rsynd_restart", outs(), 5'b01000);

    // Overlapping phases: stage 2 applies RCB while SHS is staged.
    step(1'b0, 1'b1, 1'b0, RCB, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, SHS, 1'b0, 1'b0, 1'b0);
    settle(); check("overlap_hold", outs(), 5'b01000);
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, IDLE, 1'b0, 1'b0, 1'b0);
    settle(); check("overlap_apply", outs(), 5'b11000);

    // Reset between hphi1 and hphi2 discards the staged code.
    slot(RHS, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, SHS, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, IDLE, 1'b0, 1'b0, 1'b0);
    settle(); check("reset_discard", outs(), 5'b01000);
    step(1'b0, 1'b0, 1'b1, IDLE, 1'b0, 1'b0, 1'b0);
    settle(); check("reset_no_stale", outs(), 5'b01000);

    // Randomized traffic: mostly alternating phases, occasional overlap/reset.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] code;
      logic       h1, h2, rr, s, rs, hm;
      code = ($urandom_range(0, 9) < 6) ? codes[$urandom_range(0, 4)] : 6'($urandom());
      h1 = (i % 4 == 0) || ($urandom_range(0, 15) == 0);
      h2 = (i % 4 == 2) || ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 29) == 0);
      hm = ($urandom_range(0, 19) == 0);
      step(rr, h1, h2, code, s, rs, hm);
    end
    step(1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/tia_horizontal_sync_decoder.md
TIA_HORIZONTAL_SYNC_DECODER -- requirements
Module: tia_horizontal_sync_decoder

Interface
REQ-001 SHALL have parameters (name, default, meaning), all codes distinct:
 - SHS_CODE, 6'b111100, set HSYNC
 - RHS_CODE, 6'b110111, reset HSYNC and set colour burst
 - RCB_CODE, 6'b001111, reset colour burst
 - RHB_CODE, 6'b011100, normal end of HBLANK
 - LRHB_CODE, 6'b101111, late (HMOVE-extended) end of HBLANK
REQ-002 SHALL have ports (name, direction, width, meaning):
 - clk, in, 1, sole clock
 - r, in, 1, reset; synchronous, active-high
 - hphi1, in, 1, one-clk-wide phase-1 enable
 - hphi2, in, 1, one-clk-wide phase-2 enable
 - lfsr_out, in, 6, horizontal LFSR state
 - shb, in, 1, LFSR wrap decode (start of line)
 - rsynd, in, 1, delayed RSYNC strobe
 - hmove, in, 1, HMOVE register strobe; may arrive in any cycle
 - hsync, out, 1, horizontal sync
 - hblank, out, 1, horizontal blank
 - cburst, out, 1, colour-burst gate
 - ext_blank, out, 1, current line uses extended (late) blank
 - hmove_pending, out, 1, HMOVE strobe latched but not yet consumed
REQ-003 All state SHALL update only on the rising edge of clk.
REQ-004 The block SHALL contain no combinational path from any input to any output.

Function
REQ-005 Stage 1 SHALL act only when hphi1=1: the five code comparisons, plus shb|rsynd, SHALL be registered into six stage flags, replacing their prior values.
REQ-006 Stage 2 SHALL act only when hphi2=1: it SHALL apply the stage flags to the output latches, and the outputs SHALL change at that same clk edge.
REQ-007 Latency SHALL be: code held across an hphi1 pulse -> output change at the first hphi2 edge after it.
REQ-008 When hphi1 and hphi2 are high together, stage 2 SHALL use the flags held before that edge while stage 1 loads new flags.
REQ-009 The SHS flag SHALL set hsync.
REQ-010 The RHS flag SHALL clear hsync and set cburst.
REQ-011 The RCB flag SHALL clear cburst.
REQ-012 The start flag (shb|rsynd) SHALL:
 - set hblank, clear hsync and clear cburst
 - load ext_blank with (hmove_pending | hmove)
 - clear hmove_pending
REQ-013 The RHB flag SHALL clear hblank only when ext_blank=0; otherwise it SHALL have no effect.
REQ-014 The LRHB flag SHALL clear hblank and clear ext_blank when ext_blank=1; otherwise it SHALL have no effect.
REQ-015 hmove=1 SHALL set hmove_pending in any cycle, except when REQ-012 consumes it in the same cycle; in that case the strobe applies to the current line and hmove_pending stays 0.
REQ-016 A second hmove while hmove_pending=1 SHALL be absorbed, with no additional effect.
REQ-017 Flags not asserted SHALL leave their latches unchanged, and outputs SHALL hold between hphi2 pulses.
REQ-018 rsynd arriving mid-line SHALL restart the line exactly as shb does (REQ-012), regardless of current latch states.

Reset
REQ-019 When r=1 at a clk edge, the block SHALL force:
 - hsync=0, hblank=1, cburst=0, ext_blank=0, hmove_pending=0
 - all stage flags to 0
REQ-020 r SHALL dominate hphi1, hphi2 and hmove in the same cycle.
REQ-021 After r deasserts, the first output change SHALL require a fresh hphi1 then hphi2 pair; nothing staged before reset SHALL survive.

Verification
REQ-022 The bench SHALL cover these directed scenarios, driving hphi1 and hphi2 as alternating one-clk pulses two clks apart:
 - Reset: hold r=1 for 3 clks with hmove=1 and codes toggling -> hsync=0, hblank=1, cburst=0, ext_blank=0, hmove_pending=0 on every cycle, and after release.
 - Normal line, no HMOVE: shb=1 at hphi1, then lfsr_out=111100, 110111, 001111, 011100 at successive hphi1 pulses -> at successive hphi2 edges: hblank=1; hsync=1; hsync=0 with cburst=1; cburst=0; hblank=0.
 - HMOVE extended blank: hmove pulse, then shb line -> at the shb apply edge ext_blank=1 and hmove_pending=0; 011100 leaves hblank=1; 101111 gives hblank=0 and ext_blank=0.
 - Simultaneous hmove and start apply: hmove=1 on the same edge as the hphi2 that applies shb -> ext_blank=1 and hmove_pending=0 on that edge.
 - rsynd mid-line: with hsync=1 and cburst=0, rsynd=1 at hphi1 -> next hphi2 gives hblank=1, hsync=0, cburst=0.
 - Overlapping phases and mid-operation reset: hphi1 and hphi2 together with lfsr_out=111100 -> hsync stays unchanged on that edge and sets on the next hphi2; r=1 between hphi1 and hphi2 -> that staged code never reaches the outputs.
